// File: rtl/car_sensor_pkg.sv
// Shared types and constants for the parking-lot sensor stimulus generator.
package car_sensor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PH1,
      PH2,
      PH3,
      PH4
   } gen_state_t;

   // Sensor bus encoding: [1] = outer beam, [0] = inner beam, 1 = blocked
   localparam logic [1:0] SENS_CLEAR = 2'b00;
   localparam logic [1:0] SENS_OUTER = 2'b10;
   localparam logic [1:0] SENS_INNER = 2'b01;
   localparam logic [1:0] SENS_BOTH  = 2'b11;

   // Width of the per-phase down counter
   localparam int TIMER_W = 8;

   // Beam pattern held during a phase. dir = 0 means the object meets the
   // outer beam first. A car is long enough to block both beams in PH2, while
   // a pedestrian clears the first beam before reaching the second.
   function automatic logic [1:0] phase_pattern(gen_state_t st, logic dir, logic ped);
      logic [1:0] first_beam;
      logic [1:0] second_beam;
      logic [1:0] pat;
      first_beam  = dir ? SENS_INNER : SENS_OUTER;
      second_beam = dir ? SENS_OUTER : SENS_INNER;
      case (st)
         PH1:     pat = first_beam;
         PH2:     pat = ped ? SENS_CLEAR : SENS_BOTH;
         PH3:     pat = second_beam;
         default: pat = SENS_CLEAR;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell timer: counts DWELL cycles after each load, flags the last one.
module phase_timer
   import car_sensor_pkg::*;
#(
   parameter int DWELL = 4  // cycles per phase, legal range 1..255
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire
);

   localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(DWELL - 1);

   logic [TIMER_W-1:0] count;
   logic               running;

   // Down counter; a load restarts the phase, otherwise count toward zero and stop
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         running <= 1'b0;
      end else if (load) begin
         count   <= LOAD_VAL;
         running <= 1'b1;
      end else if (running) begin
         if (count == '0) begin
            running <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   assign expire = running && (count == '0);

endmodule

// File: rtl/car_sensor_gen.sv
// Converts a one-cycle enter/exit command into the timed [outer, inner]
// photo-sensor waveform produced by a passing car or pedestrian.
module car_sensor_gen
   import car_sensor_pkg::*;
#(
   parameter int DWELL = 4  // cycles per phase, legal range 1..255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       dir,
   input  logic       ped,
   output logic [1:0] sensors,
   output logic       busy,
   output logic       done
);

   gen_state_t state;
   gen_state_t state_next;
   logic       dir_q;
   logic       ped_q;
   logic       dir_next;
   logic       ped_next;
   logic       load;
   logic       expire;
   logic [1:0] sensors_next;
   logic       busy_next;
   logic       done_next;

   phase_timer #(
      .DWELL (DWELL)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .expire (expire)
   );

   // State register and command latched on the accepting edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         dir_q <= 1'b0;
         ped_q <= 1'b0;
      end else begin
         state <= state_next;
         dir_q <= dir_next;
         ped_q <= ped_next;
      end
   end

   // Next-state logic: accept only in IDLE, step through phases on timer expiry
   always_comb begin
      state_next = state;
      load       = 1'b0;
      dir_next   = dir_q;
      ped_next   = ped_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = PH1;
               load       = 1'b1;
               dir_next   = dir;
               ped_next   = ped;
            end
         end
         PH1: begin
            if (expire) begin
               state_next = PH2;
               load       = 1'b1;
            end
         end
         PH2: begin
            if (expire) begin
               state_next = PH3;
               load       = 1'b1;
            end
         end
         PH3: begin
            if (expire) begin
               state_next = PH4;
               load       = 1'b1;
            end
         end
         PH4: begin
            if (expire) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the registered outputs line up with it
   always_comb begin
      sensors_next = phase_pattern(state_next, dir_next, ped_next);
      busy_next    = (state_next != IDLE);
      done_next    = (state == PH4) && (state_next == IDLE);
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sensors <= SENS_CLEAR;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         sensors <= sensors_next;
         busy    <= busy_next;
         done    <= done_next;
      end
   end

endmodule

// File: tb/tb_car_sensor_gen.sv
// Scoreboard bench for car_sensor_gen: three instances with DWELL = 1, 2, 3.
module tb_car_sensor_gen;

   logic       clk = 1'b0;
   logic       reset_a [3];
   logic       start_a [3];
   logic       dir_a   [3];
   logic       ped_a   [3];
   logic [1:0] sens_a  [3];
   logic       busy_a  [3];
   logic       done_a  [3];

   always #5 clk = ~clk;

   car_sensor_gen #(.DWELL(1)) u_d1 (
      .clk(clk), .reset(reset_a[0]), .start(start_a[0]), .dir(dir_a[0]), .ped(ped_a[0]),
      .sensors(sens_a[0]), .busy(busy_a[0]), .done(done_a[0]));

   car_sensor_gen #(.DWELL(2)) u_d2 (
      .clk(clk), .reset(reset_a[1]), .start(start_a[1]), .dir(dir_a[1]), .ped(ped_a[1]),
      .sensors(sens_a[1]), .busy(busy_a[1]), .done(done_a[1]));

   car_sensor_gen #(.DWELL(3)) u_d3 (
      .clk(clk), .reset(reset_a[2]), .start(start_a[2]), .dir(dir_a[2]), .ped(ped_a[2]),
      .sensors(sens_a[2]), .busy(busy_a[2]), .done(done_a[2]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {sensors, busy, done} per busy/done cycle, one queue per instance
   logic [3:0] q0[$];
   logic [3:0] q1[$];
   logic [3:0] q2[$];
   int done_cnt [3] = '{0, 0, 0};
   int done_cyc [3] = '{0, 0, 0};
   int d0_hist[$];

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int qsize(int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic void qpush(int d, logic [3:0] v);
      case (d)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endfunction

   function automatic logic [3:0] qpop(int d);
      case (d)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Hand-written phase table: PH1..PH4 packed MSB first
   function automatic logic [1:0] pat(logic dir, logic ped, int ph);
      logic [7:0] row;
      case ({ped, dir})
         2'b00:   row = 8'b10_11_01_00;
         2'b01:   row = 8'b01_11_10_00;
         2'b10:   row = 8'b10_00_01_00;
         default: row = 8'b01_00_10_00;
      endcase
      return row[7-2*ph -: 2];
   endfunction

   // Queue the expected busy cycles (possibly truncated) and optional done cycle
   function automatic void push_seq(int d, logic dir, logic ped, int n_busy, bit with_done);
      int dwell;
      dwell = d + 1;
      for (int k = 0; k < n_busy; k++)
         qpush(d, {pat(dir, ped, k / dwell), 2'b10});
      if (with_done)
         qpush(d, 4'b0001);
   endfunction

   // Monitor: every busy or done cycle must match the next queued expectation
   always @(negedge clk) begin
      logic [3:0] obs;
      for (int d = 0; d < 3; d++) begin
         obs = {sens_a[d], busy_a[d], done_a[d]};
         if (busy_a[d] || done_a[d]) begin
            if (qsize(d) == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output dut%0d cyc%0d: got %b, expected no activity", d, cyc, obs);
            end else begin
               check($sformatf("seq_dut%0d_cyc%0d", d, cyc), int'(obs), int'(qpop(d)));
            end
            if (done_a[d]) begin
               done_cnt[d]++;
               done_cyc[d] = cyc;
               if (d == 0) d0_hist.push_back(cyc);
            end
         end
      end
   end

   // Present a command for one edge; returns the cycle count of the accepting edge
   task automatic issue(int d, logic dir, logic ped, output int n);
      start_a[d] = 1'b1;
      dir_a[d]   = dir;
      ped_a[d]   = ped;
      @(posedge clk);
      #1;
      n = cyc;
      start_a[d] = 1'b0;
      dir_a[d]   = ~dir;
      ped_a[d]   = ~ped;
   endtask

   task automatic wait_done(int d, int prev, int exp_cyc, string name);
      int t;
      t = 0;
      while (done_cnt[d] == prev && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      check({name, "_done_count"}, done_cnt[d], prev + 1);
      check({name, "_done_cycle"}, done_cyc[d], exp_cyc);
      check({name, "_queue_drained"}, qsize(d), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int prev;
      int h0;

      for (int d = 0; d < 3; d++) begin
         reset_a[d] = 1'b1;
         start_a[d] = 1'b0;
         dir_a[d]   = 1'b0;
         ped_a[d]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("reset_outputs_dut%0d", d), int'({sens_a[d], busy_a[d], done_a[d]}), 0);
      for (int d = 0; d < 3; d++) reset_a[d] = 1'b0;
      @(posedge clk);
      #1;

      // Car enter, DWELL = 2
      push_seq(1, 1'b0, 1'b0, 8, 1'b1);
      prev = done_cnt[1];
      issue(1, 1'b0, 1'b0, n);
      wait_done(1, prev, n + 8, "car_enter_d2");

      // Car exit, DWELL = 1
      push_seq(0, 1'b1, 1'b0, 4, 1'b1);
      prev = done_cnt[0];
      issue(0, 1'b1, 1'b0, n);
      wait_done(0, prev, n + 4, "car_exit_d1");

      // Pedestrian enter and exit, DWELL = 3
      push_seq(2, 1'b0, 1'b1, 12, 1'b1);
      prev = done_cnt[2];
      issue(2, 1'b0, 1'b1, n);
      wait_done(2, prev, n + 12, "ped_enter_d3");
      push_seq(2, 1'b1, 1'b1, 12, 1'b1);
      prev = done_cnt[2];
      issue(2, 1'b1, 1'b1, n);
      wait_done(2, prev, n + 12, "ped_exit_d3");

      // Second command during a car-enter sequence must be dropped
      push_seq(1, 1'b0, 1'b0, 8, 1'b1);
      prev = done_cnt[1];
      issue(1, 1'b0, 1'b0, n);
      repeat (2) @(posedge clk);
      #1;
      start_a[1] = 1'b1;
      dir_a[1]   = 1'b1;
      @(posedge clk);
      #1;
      start_a[1] = 1'b0;
      wait_done(1, prev, n + 8, "ignore_busy");
      repeat (12) @(posedge clk);
      #1;
      check("ignore_busy_single_done", done_cnt[1], prev + 1);

      // Back-to-back with start held high, DWELL = 1: three sequences
      for (int s = 0; s < 3; s++) push_seq(0, 1'b0, 1'b0, 4, 1'b1);
      prev = done_cnt[0];
      h0   = d0_hist.size();
      start_a[0] = 1'b1;
      dir_a[0]   = 1'b0;
      ped_a[0]   = 1'b0;
      @(posedge clk);
      #1;
      n = cyc;
      repeat (14) @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("b2b_done_count", done_cnt[0], prev + 3);
      check("b2b_queue_drained", qsize(0), 0);
      if (d0_hist.size() >= h0 + 3) begin
         check("b2b_first_done", d0_hist[h0], n + 4);
         check("b2b_period_1", d0_hist[h0+1] - d0_hist[h0], 5);
         check("b2b_period_2", d0_hist[h0+2] - d0_hist[h0+1], 5);
      end else begin
         check("b2b_hist_size", d0_hist.size(), h0 + 3);
      end

      // Reset during PH2 of a car exit, DWELL = 2
      push_seq(1, 1'b1, 1'b0, 3, 1'b0);
      prev = done_cnt[1];
      issue(1, 1'b1, 1'b0, n);
      repeat (2) @(posedge clk);
      #1;
      reset_a[1] = 1'b1;
      @(posedge clk);
      #1;
      reset_a[1] = 1'b0;
      check("abort_outputs_cleared", int'({sens_a[1], busy_a[1], done_a[1]}), 0);
      repeat (15) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt[1], prev);
      check("abort_queue_drained", qsize(1), 0);
      push_seq(1, 1'b1, 1'b0, 8, 1'b1);
      prev = done_cnt[1];
      issue(1, 1'b1, 1'b0, n);
      wait_done(1, prev, n + 8, "after_abort");

      // Reset and start on the same edge: command dropped
      prev = done_cnt[2];
      reset_a[2] = 1'b1;
      start_a[2] = 1'b1;
      dir_a[2]   = 1'b0;
      ped_a[2]   = 1'b0;
      @(posedge clk);
      #1;
      reset_a[2] = 1'b0;
      start_a[2] = 1'b0;
      check("reset_wins_outputs", int'({sens_a[2], busy_a[2], done_a[2]}), 0);
      repeat (20) @(posedge clk);
      #1;
      check("reset_wins_no_done", done_cnt[2], prev);

      for (int d = 0; d < 3; d++)
         check($sformatf("final_queue_empty_dut%0d", d), qsize(d), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/car_sensor_gen.md
# car_sensor_gen

Sensor-stimulus generator for the parking-lot gate: it converts a one-cycle command ("car enters", "car exits", "pedestrian enters", "pedestrian exits") into the timed 2-bit photo-sensor waveform that a physical vehicle or person would produce. It drives the same `[outer, inner]` sensor bus consumed by the lot's car-detection FSM. It serves as an on-board emulator, selected by switches on the DE1-SoC, and as a reusable stimulus source for benches.

## Interface
- `DWELL`, default 4: cycles each sensor phase is held; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `dir`  in  1  0 = enter (outer first), 1 = exit (inner first); sampled with `start`.
- `ped`  in  1  0 = car, 1 = pedestrian; sampled with `start`.
- `sensors`  out  2  [1] = outer, [0] = inner; 1 = beam blocked.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse after a sequence completes.

## Operation
- States: IDLE, PH1, PH2, PH3, PH4. Each PHx is held for exactly DWELL cycles, then the FSM advances. PH4 returns to IDLE.
- `dir` and `ped` are latched on the accepting edge. Later changes have no effect until the next accepted `start`.
- Phase patterns (PH1, PH2, PH3, PH4):
  - car enter: 10, 11, 01, 00
  - car exit: 01, 11, 10, 00
  - ped enter: 10, 00, 01, 00
  - ped exit: 01, 00, 10, 00
- Pedestrian patterns never assert both bits, so a downstream filter must reject them.
- IDLE: `sensors` = 00, `busy` = 0.
- `start` while `busy` = 1 is ignored; it is not queued.
- Phase timer is an 8-bit down counter. It loads DWELL-1 on phase entry and advances the phase when it reaches 0. DWELL = 1 means one cycle per phase.

## Timing
- Reset values: `sensors` = 00, `busy` = 0, `done` = 0, state = IDLE, counter = 0, latched dir/ped = 0.
- All outputs are registered.
- `start` sampled high at edge N (IDLE): from cycle N+1, `sensors` = PH1 pattern and `busy` = 1.
- The sequence occupies 4*DWELL cycles: N+1 .. N+4*DWELL.
- At cycle N+4*DWELL+1: `busy` = 0, `sensors` = 00, `done` = 1 for exactly that cycle.
- A `start` sampled in the `done` cycle is accepted, giving back-to-back sequences with no extra idle cycle.
- `reset` mid-sequence: at the next cycle `sensors` = 00, `busy` = 0, `done` = 0. No `done` is emitted for the aborted sequence.
- `reset` and `start` high on the same edge: reset wins, and the command is dropped.

## Structure
- Package `car_sensor_pkg` contains:
  - the state enum `gen_state_t` {IDLE, PH1, PH2, PH3, PH4};
  - sensor constants `SENS_CLEAR` = 2'b00, `SENS_OUTER` = 2'b10, `SENS_INNER` = 2'b01, `SENS_BOTH` = 2'b11.
- Sub-module `phase_timer`:
  - parameterised by DWELL;
  - inputs: `load`, `clk`, `reset`;
  - output: `expire`, a combinational flag for count == 0 while running.
- Top level holds the FSM, the latched command, the pattern mux, and the output registers.

## Test plan
- Car enter, DWELL = 2, `start` = 1, `dir` = 0, `ped` = 0 at edge 0:
  - `sensors` = 10, 10, 11, 11, 01, 01, 00, 00 on cycles 1–8, with `busy` = 1 throughout;
  - cycle 9: `done` = 1, `busy` = 0.
- Car exit, DWELL = 1: `sensors` = 01, 11, 10, 00 on cycles 1–4; `done` = 1 on cycle 5.
- Pedestrian enter, DWELL = 3:
  - patterns 10×3, 00×3, 01×3, 00×3;
  - `sensors` never equals 11 during the sequence.
- Command ignored while busy:
  - second `start` with `dir` = 1 at cycle 3 of a car-enter sequence, DWELL = 2;
  - the sequence is unchanged and exactly one `done` pulse occurs.
- Back-to-back: `start` held high continuously, DWELL = 1:
  - the `done` cycle also re-accepts;
  - the next PH1 appears on the cycle after `done`;
  - the period is 5 cycles.
- Reset abort: `reset` pulsed during PH2 of a car exit:
  - next cycle `sensors` = 00, `busy` = 0, and no `done` pulse follows;
  - a subsequent `start` runs a full sequence normally.
